// File: rtl/chunked_adder_pkg.sv
// Shared definitions for the slice-serial adder: controller states and the
// helper that sizes the slice index register.
package chunked_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // A single-slice configuration still needs a one-bit index register.
    function automatic int idx_width(input int nslice);
        return (nslice > 1) ? $clog2(nslice) : 1;
    endfunction

    localparam int DEFAULT_IDX_WIDTH = idx_width(16 / 4);

endpackage

// File: rtl/chunked_adder_rca_slice.sv
// SLICE-bit ripple chain of full-adder cells. It also exposes the carry into
// the top bit, which the parent uses for signed overflow detection.
module rca_slice #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] s,
    output logic             cout,
    output logic             ctop
);

    always_comb begin
        logic [SLICE:0] c;
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int i = 0; i < SLICE; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
        end
        cout = c[SLICE];
        ctop = c[SLICE-1];
    end

endmodule

// File: rtl/chunked_adder.sv
// Slice-serial adder/subtractor: one SLICE-bit ripple slice is reused over
// NSLICE clocks, with a valid/ready handshake on both operands and result.
module chunked_adder
    import chunked_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int            NSLICE = WIDTH / SLICE;
    localparam int            KW     = idx_width(NSLICE);
    localparam logic [KW-1:0] K_LAST = KW'(NSLICE - 1);

    state_t            state;
    state_t            state_nxt;
    logic [KW-1:0]     k;
    logic [WIDTH-1:0]  a_r;
    logic [WIDTH-1:0]  b_r;
    logic              carry;
    logic [SLICE-1:0]  slice_a;
    logic [SLICE-1:0]  slice_b;
    logic [SLICE-1:0]  slice_sum;
    logic              slice_cout;
    logic              slice_ctop;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    assign slice_a = a_r[int'(k) * SLICE +: SLICE];
    assign slice_b = b_r[int'(k) * SLICE +: SLICE];

    rca_slice #(
        .SLICE (SLICE)
    ) u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry),
        .s    (slice_sum),
        .cout (slice_cout),
        .ctop (slice_ctop)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)   state_nxt = RUN;
            RUN:     if (k == K_LAST) state_nxt = DONE;
            DONE:    if (out_ready)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Subtraction is A + ~B + ~cin, so the stored carry doubles as "no borrow".
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            k     <= '0;
            a_r   <= '0;
            b_r   <= '0;
            carry <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r   <= a;
                        b_r   <= sub ? ~b : b;
                        carry <= sub ? ~cin : cin;
                        k     <= '0;
                    end
                end
                RUN: begin
                    sum[int'(k) * SLICE +: SLICE] <= slice_sum;
                    carry <= slice_cout;
                    k     <= k + 1'b1;
                    if (k == K_LAST) begin
                        cout <= slice_cout;
                        ovf  <= slice_ctop ^ slice_cout;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_chunked_adder.sv
// Bench for chunked_adder: a 16/4 instance and an 8/8 instance, checked
// against an integer-arithmetic model of add/subtract with carry and overflow.
module tb_chunked_adder;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
    logic [15:0] a, b, sum;

    logic        n_in_valid, n_in_ready, n_cin, n_sub, n_out_valid, n_out_ready, n_cout, n_ovf;
    logic [7:0]  n_a, n_b, n_sum;

    int checkCount = 0;
    int passCount  = 0;

    always #5 clk = ~clk;

    chunked_adder #(.WIDTH(16), .SLICE(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
    );

    chunked_adder #(.WIDTH(8), .SLICE(8)) dut_narrow (
        .clk(clk), .rst_n(rst_n), .in_valid(n_in_valid), .in_ready(n_in_ready),
        .a(n_a), .b(n_b), .cin(n_cin), .sub(n_sub), .out_valid(n_out_valid),
        .out_ready(n_out_ready), .sum(n_sum), .cout(n_cout), .ovf(n_ovf)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected)
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        else
            passCount++;
    endtask

    // Reference: plain integer arithmetic, unsigned for sum/carry, signed for overflow.
    function automatic void model(input int w, input longint ua, input longint ub, input bit ci,
                                  input bit is_sub, output longint esum, output bit ecout, output bit eovf);
        longint c, full, half, sa, sb, sres;
        c    = ci ? 64'sd1 : 64'sd0;
        half = 64'sd1 <<< (w - 1);
        full = is_sub ? (ua - ub - c) : (ua + ub + c);
        esum = full & ((64'sd1 <<< w) - 64'sd1);
        ecout = is_sub ? (full >= 0) : (full >= (64'sd1 <<< w));
        sa   = (ua >= half) ? ua - 2 * half : ua;
        sb   = (ub >= half) ? ub - 2 * half : ub;
        sres = is_sub ? (sa - sb - c) : (sa + sb + c);
        eovf = (sres >= half) || (sres < -half);
    endfunction

    function automatic logic sel_valid(input bit narrow);
        return narrow ? n_out_valid : out_valid;
    endfunction

    function automatic logic sel_ready(input bit narrow);
        return narrow ? n_in_ready : in_ready;
    endfunction

    function automatic logic [31:0] sel_sum(input bit narrow);
        return narrow ? 32'(n_sum) : 32'(sum);
    endfunction

    task automatic drive(input bit narrow, input logic v, input logic [15:0] ta, input logic [15:0] tb_op,
                         input logic tc, input logic ts, input logic ord);
        if (narrow) begin
            n_in_valid = v; n_a = ta[7:0]; n_b = tb_op[7:0]; n_cin = tc; n_sub = ts; n_out_ready = ord;
        end else begin
            in_valid = v; a = ta; b = tb_op; cin = tc; sub = ts; out_ready = ord;
        end
    endtask

    // One operation: accept, measure latency, hold the result for 'hold' cycles
    // with in_valid chattering, then release it.
    task automatic applyStimulus(input bit narrow, input logic [15:0] ta, input logic [15:0] tb_op,
                                 input logic tc, input logic ts, input int hold);
        longint es;
        bit     ec, eo;
        int     lat;
        int     w;
        w = narrow ? 8 : 16;
        model(w, longint'(narrow ? {8'h00, ta[7:0]} : ta), longint'(narrow ? {8'h00, tb_op[7:0]} : tb_op),
              tc, ts, es, ec, eo);
        @(negedge clk);
        checkOutput("in_ready_idle", 32'(sel_ready(narrow)), 32'd1);
        drive(narrow, 1'b1, ta, tb_op, tc, ts, 1'b0);
        @(posedge clk);
        @(negedge clk);
        drive(narrow, 1'b0, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b0);
        lat = 0;
        while (!sel_valid(narrow) && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        checkOutput("latency", 32'(lat), narrow ? 32'd1 : 32'd4);
        for (int h = 0; h <= hold; h++) begin
            if (h > 0) begin
                drive(narrow, 1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b0);
                @(posedge clk);
                @(negedge clk);
                checkOutput("out_valid_hold", 32'(sel_valid(narrow)), 32'd1);
            end
            checkOutput("in_ready_busy", 32'(sel_ready(narrow)), 32'd0);
            checkOutput("sum", sel_sum(narrow), 32'(es));
            checkOutput("cout", 32'(narrow ? n_cout : cout), 32'(ec));
            checkOutput("ovf", 32'(narrow ? n_ovf : ovf), 32'(eo));
        end
        drive(narrow, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        drive(narrow, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("out_valid_release", 32'(sel_valid(narrow)), 32'd0);
        checkOutput("in_ready_release", 32'(sel_ready(narrow)), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic seen_valid;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_sum", 32'(sum), 32'd0);
        checkOutput("rst_cout_ovf", 32'({cout, ovf}), 32'd0);
        checkOutput("rst_narrow_ready", 32'(n_in_ready), 32'd1);
        rst_n = 1'b1;

        applyStimulus(1'b0, 16'h1234, 16'h1111, 1'b0, 1'b0, 0);
        applyStimulus(1'b0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
        applyStimulus(1'b0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);
        applyStimulus(1'b0, 16'h0005, 16'h0007, 1'b0, 1'b1, 0);
        applyStimulus(1'b0, 16'h8000, 16'h0001, 1'b0, 1'b1, 0);
        applyStimulus(1'b0, 16'hA5A5, 16'h1234, 1'b1, 1'b0, 3);

        // Reset lands in the second RUN cycle; nothing from that operation may surface.
        @(negedge clk);
        drive(1'b0, 1'b1, 16'h1234, 16'h1111, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("midrun_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midrun_in_ready", 32'(in_ready), 32'd1);
        checkOutput("midrun_sum", 32'(sum), 32'd0);
        seen_valid = 1'b0;
        repeat (6) begin
            @(posedge clk);
            @(negedge clk);
            seen_valid = seen_valid | out_valid;
        end
        checkOutput("midrun_no_pulse", 32'(seen_valid), 32'd0);
        out_ready = 1'b0;
        applyStimulus(1'b0, 16'h0001, 16'h0001, 1'b0, 1'b0, 0);

        applyStimulus(1'b1, 16'h0080, 16'h0080, 1'b0, 1'b0, 0);

        for (int i = 0; i < 30; i++)
            applyStimulus(1'b0, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
        for (int i = 0; i < 10; i++)
            applyStimulus(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 2)));

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/chunked_adder.md
CHUNKED_ADDER -- requirements
Module: chunked_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width in bits.
REQ-002 SHALL have parameter SLICE, default 4, bits processed per clock; WIDTH % SLICE == 0 and 1 <= SLICE <= WIDTH are required. NSLICE = WIDTH/SLICE.
REQ-003 SHALL have ports, one per line (name, direction, width, meaning):
  clk  in  1  single clock, rising edge.
  rst_n  in  1  reset, synchronous, active-low.
  in_valid  in  1  operands present.
  in_ready  out  1  block can accept operands.
  a  in  WIDTH  operand A.
  b  in  WIDTH  operand B.
  cin  in  1  carry-in (add) / borrow-in (sub).
  sub  in  1  0 = A+B+cin; 1 = A-B-cin.
  out_valid  out  1  result present.
  out_ready  in  1  consumer accepts result.
  sum  out  WIDTH  result.
  cout  out  1  raw carry out of MSB (sub: 1 = no borrow).
  ovf  out  1  two's-complement signed overflow.
REQ-004 SHALL use one clock; reset is synchronous and active-low.

Function
REQ-005 SHALL implement FSM states IDLE, RUN, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-006 IDLE: on in_valid&&in_ready SHALL capture a, b_eff = sub ? ~b : b, carry = sub ? ~cin : cin, clear slice index k=0, go RUN.
REQ-007 RUN: each cycle SHALL add slice k of a and b_eff with the carry register, write sum[k*SLICE +: SLICE], update carry, increment k.
REQ-008 RUN: after processing k==NSLICE-1 SHALL go DONE, load cout with the MSB carry-out and ovf with (carry into MSB) XOR (carry out of MSB).
REQ-009 Latency: operands accepted on edge T SHALL yield out_valid high from edge T+NSLICE (SLICE==WIDTH gives latency 1).
REQ-010 DONE: sum, cout, ovf SHALL hold stable while out_valid&&!out_ready; on out_valid&&out_ready SHALL go IDLE.
REQ-011 in_valid SHALL be ignored in RUN and DONE; no overlap; back-to-back throughput is one operation per NSLICE+2 cycles with out_ready tied high.
REQ-012 Arithmetic SHALL wrap modulo 2^WIDTH; all-ones + 1 gives sum 0, cout 1.
REQ-013 sum bits of slices not yet processed SHALL hold their previous value during RUN; only DONE outputs are valid.

Reset
REQ-014 rst_n low at a rising edge SHALL force state IDLE, k=0, carry=0, sum=0, cout=0, ovf=0; out_valid=0 and in_ready=1 from the next cycle.
REQ-015 Reset in RUN or DONE SHALL discard the operation in flight, with no out_valid pulse.

Structure
REQ-016 A shared package SHALL hold the FSM state typedef and the slice-index width constant ($clog2(NSLICE), minimum 1).
REQ-017 SHALL instantiate one sub-module rca_slice (SLICE-bit ripple chain of full-adder cells; outputs slice sum, carry-out, carry into top bit).

Verification
REQ-018 WIDTH=16, SLICE=4, add 0x1234+0x1111 cin=0 -> sum 0x2345, cout 0, ovf 0, out_valid exactly 4 cycles after accept.
REQ-019 add 0xFFFF+0x0001 -> sum 0x0000, cout 1, ovf 0; add 0x7FFF+0x0001 -> sum 0x8000, cout 0, ovf 1.
REQ-020 sub 0x0005-0x0007 cin=0 -> sum 0xFFFE, cout 0, ovf 0; sub 0x8000-0x0001 -> sum 0x7FFF, cout 1, ovf 1.
REQ-021 out_ready low 3 cycles in DONE with in_valid pulsing -> outputs held, in_ready 0, no capture; out_ready high -> IDLE next cycle.
REQ-022 rst_n low during the 2nd RUN cycle -> IDLE, out_valid 0, sum 0 next cycle; a following 0x0001+0x0001 -> 0x0002.
REQ-023 WIDTH=8, SLICE=8: 0x80+0x80 -> sum 0x00, cout 1, ovf 1, latency 1 cycle.
